// File: rtl/regs_uart_fifo.sv
// APB CSR block for the SoC UART: CTRL/STAT/IER registers plus TX and RX byte FIFOs that
// sit between the APB bus and the serial core, with overflow flags and a maskable irq.
module regs_uart_fifo #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] BR_RST     = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [3:0]        pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              ctrl_en_out,
    output logic [3:0]        ctrl_br_out,
    output logic [7:0]        ctrl_clk_out,
    output logic [7:0]        tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic              irq_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

    localparam logic [ADDR_W-1:0] OFF_CTRL = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] OFF_TXD  = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] OFF_RXD  = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] OFF_IER  = ADDR_W'(32'h10);

    logic              en_q;
    logic [3:0]        br_q;
    logic [7:0]        clk_mhz_q;
    logic [2:0]        ier_q;
    logic              tx_ovf_q;
    logic              rx_ovf_q;
    logic              irq_q;
    logic              rd_phase_q;
    logic              rd_pop_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_mux;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [PW-1:0] tx_cnt, rx_cnt;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]    rx_head;

    logic access, wr_acc, rd_first, rd_done, wr_ok;
    logic sel_ctrl, sel_stat, sel_txd, sel_rxd, sel_ier, mapped;
    logic ctrl_lo_wr, ctrl_hi_wr, stat_w1c, ier_wr;
    logic tx_flush, tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic rx_flush, rx_push_req, rx_push, rx_pop, rx_ovf_set;
    logic unused_bits;

    assign sel_ctrl = (paddr == OFF_CTRL);
    assign sel_stat = (paddr == OFF_STAT);
    assign sel_txd  = (paddr == OFF_TXD);
    assign sel_rxd  = (paddr == OFF_RXD);
    assign sel_ier  = (paddr == OFF_IER);
    assign mapped   = sel_ctrl | sel_stat | sel_txd | sel_rxd | sel_ier;

    // A read spends its first access cycle registering prdata; the second cycle completes it.
    assign access   = psel & penable;
    assign wr_acc   = access & pwrite;
    assign rd_first = access & ~pwrite & ~rd_phase_q;
    assign rd_done  = access & ~pwrite & rd_phase_q;
    assign wr_ok    = wr_acc & mapped;

    assign ctrl_lo_wr = wr_ok & sel_ctrl & pstrb[0];
    assign ctrl_hi_wr = wr_ok & sel_ctrl & pstrb[1];
    assign stat_w1c   = wr_ok & sel_stat & pstrb[0];
    assign ier_wr     = wr_ok & sel_ier & pstrb[0];
    assign tx_flush   = ctrl_lo_wr & pwdata[1];
    assign rx_flush   = ctrl_lo_wr & pwdata[2];

    assign pready  = ~rd_first;
    assign pslverr = ~mapped & (wr_acc | rd_done);
    assign prdata  = rd_done ? rd_data_q : '0;

    // tx_valid_out/tx_ready_in: a byte moves on every posedge where both are high;
    // tx_valid_out never depends on tx_ready_in and the head is stable while valid waits.
    assign tx_cnt       = tx_wptr_q - tx_rptr_q;
    assign tx_empty     = (tx_cnt == '0);
    assign tx_full      = (tx_cnt == FULL_CNT);
    assign tx_valid_out = en_q & ~tx_empty;
    assign tx_data_out  = tx_mem[tx_rptr_q[AW-1:0]];
    assign tx_pop       = tx_valid_out & tx_ready_in;
    assign tx_push_req  = wr_ok & sel_txd & pstrb[0];
    assign tx_push      = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf_set   = tx_push_req & tx_full & ~tx_pop & ~tx_flush;

    assign rx_cnt      = rx_wptr_q - rx_rptr_q;
    assign rx_empty    = (rx_cnt == '0);
    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_head     = rx_mem[rx_rptr_q[AW-1:0]];
    assign rx_push_req = en_q & rx_valid_in;
    assign rx_pop      = rd_done & sel_rxd & rd_pop_q;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovf_set  = rx_push_req & rx_full & ~rx_pop & ~rx_flush;

    assign ctrl_en_out  = en_q;
    assign ctrl_br_out  = br_q;
    assign ctrl_clk_out = clk_mhz_q;
    assign irq_out      = irq_q;
    assign unused_bits  = ^{pwdata, pstrb};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else if (tx_flush) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else if (rx_flush) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push & ~tx_flush) tx_mem[tx_wptr_q[AW-1:0]] <= pwdata[7:0];
        if (rx_push & ~rx_flush) rx_mem[rx_wptr_q[AW-1:0]] <= rx_data_in;
    end

    // Hardware overflow set outranks a W1C clear landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            br_q      <= BR_RST;
            clk_mhz_q <= '0;
            ier_q     <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ovf_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (ctrl_lo_wr) begin
                en_q <= pwdata[0];
                br_q <= pwdata[7:4];
            end
            if (ctrl_hi_wr) clk_mhz_q <= pwdata[15:8];
            if (ier_wr)     ier_q     <= pwdata[2:0];
            if (tx_ovf_set)                  tx_ovf_q <= 1'b1;
            else if (stat_w1c & pwdata[4])   tx_ovf_q <= 1'b0;
            if (rx_ovf_set)                  rx_ovf_q <= 1'b1;
            else if (stat_w1c & pwdata[5])   rx_ovf_q <= 1'b0;
            irq_q <= |(ier_q & {tx_ovf_q | rx_ovf_q, tx_empty, ~rx_empty});
        end
    end

    always_comb begin
        rd_mux = '0;
        if (sel_ctrl)
            rd_mux = DATA_W'({clk_mhz_q, br_q, 3'b000, en_q});
        else if (sel_stat)
            rd_mux = DATA_W'({8'(rx_cnt), 8'(tx_cnt), 2'b00, rx_ovf_q, tx_ovf_q,
                              rx_full, ~rx_empty, tx_empty, tx_full});
        else if (sel_rxd & ~rx_empty)
            rd_mux = DATA_W'(rx_head);
        else if (sel_ier)
            rd_mux = DATA_W'(ier_q);
    end

    // The RX pop decision is latched with the data so the completing cycle pops exactly once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_phase_q <= 1'b0;
            rd_pop_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_phase_q <= rd_first;
            if (rd_first) begin
                rd_data_q <= rd_mux;
                rd_pop_q  <= sel_rxd & ~rx_empty;
            end
        end
    end
endmodule

// File: tb/tb_regs_uart_fifo.sv
// Bench for regs_uart_fifo: directed scenarios plus a randomized phase, all checked against a
// queue-based model of the register map and both FIFOs.
module tb_regs_uart_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic [31:0] paddr = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        ctrl_en_out;
    logic [3:0]  ctrl_br_out;
    logic [7:0]  ctrl_clk_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in = 1'b0;
    logic [7:0]  rx_data_in = '0;
    logic        rx_valid_in = 1'b0;
    logic        irq_out;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic       m_en, m_txovf, m_rxovf;
    logic [2:0] m_ier;
    logic [3:0] m_br;
    logic [7:0] m_clk;

    regs_uart_fifo #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH), .BR_RST(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .paddr(paddr), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .ctrl_en_out(ctrl_en_out), .ctrl_br_out(ctrl_br_out),
        .ctrl_clk_out(ctrl_clk_out), .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out),
        .tx_ready_in(tx_ready_in), .rx_data_in(rx_data_in), .rx_valid_in(rx_valid_in),
        .irq_out(irq_out)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // scoreboard helpers
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s = '0;
        if (tx_exp_q.size() == DEPTH) s[0] = 1'b1;
        if (tx_exp_q.size() == 0)     s[1] = 1'b1;
        if (rx_exp_q.size() > 0)      s[2] = 1'b1;
        if (rx_exp_q.size() == DEPTH) s[3] = 1'b1;
        s[4] = m_txovf;
        s[5] = m_rxovf;
        s[15:8]  = 8'(tx_exp_q.size());
        s[23:16] = 8'(rx_exp_q.size());
        return s;
    endfunction

    function automatic logic exp_irq();
        logic r;
        r = 1'b0;
        if (m_ier[0] && rx_exp_q.size() > 0)     r = 1'b1;
        if (m_ier[1] && tx_exp_q.size() == 0)    r = 1'b1;
        if (m_ier[2] && (m_txovf || m_rxovf))    r = 1'b1;
        return r;
    endfunction

    function automatic void model_tx_push(input logic [7:0] b);
        if (tx_exp_q.size() == DEPTH) m_txovf = 1'b1;
        else tx_exp_q.push_back(b);
    endfunction

    function automatic void model_rx_push(input logic [7:0] b);
        if (!m_en) return;
        if (rx_exp_q.size() == DEPTH) m_rxovf = 1'b1;
        else rx_exp_q.push_back(b);
    endfunction

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tx_ready_in = 1'b0; rx_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tx_exp_q.delete();
        rx_exp_q.delete();
        m_en = 1'b0; m_br = 4'hF; m_clk = 8'h00; m_ier = 3'b000;
        m_txovf = 1'b0; m_rxovf = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic rx_v, input logic [7:0] rx_b,
                             input logic exp_err, input string tag);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data; pstrb = strb;
        @(negedge clk);
        penable = 1'b1;
        rx_valid_in = rx_v; rx_data_in = rx_b;
        #1;
        check({tag, "_wr_pready"}, pready, 1);
        check({tag, "_wr_pslverr"}, pslverr, exp_err);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid_in = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, input logic rx_v, input logic [7:0] rx_b,
                            output logic [31:0] data, output logic err, input string tag);
        int n;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check({tag, "_wait_pready"}, pready, 0);
        check({tag, "_wait_prdata"}, prdata, 0);
        @(negedge clk);
        rx_valid_in = rx_v; rx_data_in = rx_b;
        #1;
        n = 0;
        while (pready !== 1'b1 && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_done_pready"}, pready, 1);
        data = prdata;
        err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rx_valid_in = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic e;
        apb_read(addr, 1'b0, 8'h00, d, e, tag);
        check({tag, "_prdata"}, d, exp);
        check({tag, "_pslverr"}, e, 0);
    endtask

    task automatic read_rx(input logic rx_v, input logic [7:0] rx_b, input string tag);
        logic [31:0] d, exp;
        logic e;
        exp = (rx_exp_q.size() > 0) ? {24'h0, rx_exp_q[0]} : 32'h0;
        apb_read(32'h0C, rx_v, rx_b, d, e, tag);
        check({tag, "_prdata"}, d, exp);
        if (rx_exp_q.size() > 0) void'(rx_exp_q.pop_front());
        if (rx_v) model_rx_push(rx_b);
    endtask

    task automatic tx_write(input logic [7:0] b);
        apb_write(32'h08, {$urandom_range(0, 65535), 8'h00, b}, 4'b0001, 1'b0, 8'h00, 1'b0, "txd");
        model_tx_push(b);
    endtask

    task automatic ctrl_write(input logic [31:0] data, input logic [3:0] strb,
                              input logic rx_v, input logic [7:0] rx_b);
        apb_write(32'h00, data, strb, rx_v, rx_b, 1'b0, "ctrl");
        if (strb[0] && data[2]) rx_exp_q.delete();
        else if (rx_v) model_rx_push(rx_b);
        if (strb[0] && data[1]) tx_exp_q.delete();
        if (strb[0]) begin
            m_en = data[0];
            m_br = data[7:4];
        end
        if (strb[1]) m_clk = data[15:8];
    endtask

    task automatic stat_write(input logic [31:0] data, input logic rx_v, input logic [7:0] rx_b);
        logic hw_set;
        hw_set = rx_v && m_en && rx_exp_q.size() == DEPTH;
        apb_write(32'h04, data, 4'b0001, rx_v, rx_b, 1'b0, "stat");
        if (rx_v) model_rx_push(rx_b);
        if (data[4]) m_txovf = 1'b0;
        if (data[5] && !hw_set) m_rxovf = 1'b0;
    endtask

    task automatic ier_write(input logic [2:0] v);
        apb_write(32'h10, {29'h0, v}, 4'b0001, 1'b0, 8'h00, 1'b0, "ier");
        m_ier = v;
    endtask

    task automatic rx_push_core(input logic [7:0] b);
        @(negedge clk);
        rx_valid_in = 1'b1; rx_data_in = b;
        @(negedge clk);
        rx_valid_in = 1'b0;
        model_rx_push(b);
    endtask

    task automatic core_pop();
        logic has;
        @(negedge clk);
        #1;
        has = m_en && tx_exp_q.size() > 0;
        check("core_tx_valid", tx_valid_out, has);
        if (has) check("core_tx_data", tx_data_out, tx_exp_q[0]);
        tx_ready_in = 1'b1;
        @(negedge clk);
        tx_ready_in = 1'b0;
        if (has) void'(tx_exp_q.pop_front());
    endtask

    task automatic check_irq(input string tag);
        @(negedge clk);
        #1;
        check(tag, irq_out, exp_irq());
    endtask

    // directed and random stimulus
    initial begin
        logic [31:0] d;
        logic e;
        int op;

        do_reset();
        @(negedge clk);
        #1;
        check("rst_pready", pready, 1);
        check("rst_prdata", prdata, 0);
        check("rst_pslverr", pslverr, 0);
        check("rst_irq", irq_out, 0);
        check("rst_tx_valid", tx_valid_out, 0);
        read_check(32'h00, 32'h000000F0, "rst_ctrl");
        read_check(32'h04, 32'h00000002, "rst_stat");

        // TX fill, overflow and ordered drain
        ctrl_write(32'h000032F1, 4'b0011, 1'b0, 8'h00);
        check("ctrl_outputs", {ctrl_clk_out, ctrl_br_out, ctrl_en_out}, {m_clk, m_br, m_en});
        for (int i = 0; i < DEPTH; i++) tx_write(8'(8'h41 + i));
        read_check(32'h04, 32'h00000801, "tx_full_stat");
        tx_write(8'h49);
        read_check(32'h04, 32'h00000811, "tx_ovf_stat");
        @(negedge clk);
        tx_ready_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("drain_valid", tx_valid_out, 1);
            check("drain_data", tx_data_out, tx_exp_q.pop_front());
            @(negedge clk);
        end
        #1;
        check("drain_empty_valid", tx_valid_out, 0);
        tx_ready_in = 1'b0;
        stat_write(32'h00000010, 1'b0, 8'h00);
        read_check(32'h04, 32'h00000002, "tx_ovf_w1c");

        // RX push raises irq two cycles later; RXDATA read pops it
        ier_write(3'b001);
        rx_push_core(8'h5A);
        #1;
        check("irq_not_yet", irq_out, 0);
        @(negedge clk);
        #1;
        check("irq_rise", irq_out, 1);
        read_rx(1'b0, 8'h00, "rx_5a");
        read_check(32'h04, 32'h00000002, "rx_popped_stat");
        check("irq_fall", irq_out, 0);

        // RX full with push and pop together, overflow, W1C races
        for (int i = 0; i < DEPTH; i++) rx_push_core(8'($urandom_range(0, 255)));
        read_check(32'h04, 32'h0008000E, "rx_full_stat");
        read_rx(1'b1, 8'hC3, "rx_pushpop");
        read_check(32'h04, 32'h0008000E, "rx_pushpop_stat");
        rx_push_core(8'h77);
        read_check(32'h04, 32'h0008002E, "rx_ovf_stat");
        stat_write(32'h00000020, 1'b1, 8'h99);
        read_check(32'h04, 32'h0008002E, "w1c_vs_set");
        stat_write(32'h00000020, 1'b0, 8'h00);
        read_check(32'h04, exp_stat(), "rx_ovf_cleared");
        for (int i = 0; i < DEPTH; i++) read_rx(1'b0, 8'h00, "rx_drain");
        read_rx(1'b0, 8'h00, "rx_empty_read");

        // flush both FIFOs, flush beats a coincident RX push
        for (int i = 0; i < 3; i++) rx_push_core(8'($urandom_range(0, 255)));
        tx_write(8'h11);
        tx_write(8'h22);
        ctrl_write(32'h000000F6, 4'b0001, 1'b1, 8'hAB);
        #1;
        check("flush_tx_valid", tx_valid_out, 0);
        read_check(32'h04, 32'h00000002, "flush_stat");
        read_check(32'h00, 32'h000032F0, "flush_ctrl");
        rx_push_core(8'h55);
        read_check(32'h04, exp_stat(), "en0_rx_ignored");
        tx_write(8'h66);
        check("en0_tx_valid", tx_valid_out, 0);
        read_check(32'h04, 32'h00000100, "en0_tx_push");
        ctrl_write(32'h000000F2, 4'b0001, 1'b0, 8'h00);

        // randomized phase
        ctrl_write(32'h000000F1, 4'b0001, 1'b0, 8'h00);
        ier_write(3'b111);
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1: tx_write(8'($urandom_range(0, 255)));
                2, 3: rx_push_core(8'($urandom_range(0, 255)));
                4: read_rx(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rnd_rx");
                5: core_pop();
                6: stat_write(32'($urandom_range(0, 3)) << 4, 1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 255)));
                default: ctrl_write(32'h000000F0 | 32'($urandom_range(0, 7)), 4'b0001,
                                    1'b0, 8'h00);
            endcase
            check_irq("rnd_irq");
            read_check(32'h04, exp_stat(), "rnd_stat");
        end

        // unmapped access and reset in the middle of a read
        apb_read(32'h14, 1'b0, 8'h00, d, e, "unmapped_rd");
        check("unmapped_rd_prdata", d, 0);
        check("unmapped_rd_pslverr", e, 1);
        apb_write(32'h14, 32'hFFFFFFFF, 4'b1111, 1'b0, 8'h00, 1'b1, "unmapped_wr");
        read_check(32'h04, exp_stat(), "unmapped_no_effect");
        tx_write(8'hA5);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check("midrd_wait", pready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        tx_exp_q.delete();
        rx_exp_q.delete();
        m_en = 1'b0; m_br = 4'hF; m_clk = 8'h00; m_ier = 3'b000;
        m_txovf = 1'b0; m_rxovf = 1'b0;
        #1;
        check("midrd_pready", pready, 1);
        check("midrd_prdata", prdata, 0);
        check("midrd_tx_valid", tx_valid_out, 0);
        check("midrd_irq", irq_out, 0);
        read_check(32'h04, 32'h00000002, "post_rst_stat");
        read_check(32'h00, 32'h000000F0, "post_rst_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
